vertex_fetch: RTL and testbench
===============================

VERTEX_FETCH -- requirements
Module: vertex_fetch

Interface
- REQ-001: Parameter DEPTH, default 1024; vertex buffer entries; power of two. AW = $clog2(DEPTH).
- REQ-002: Parameter DW, default 64; vertex word width; only 64 is supported.
- REQ-003: CLK  in  1  single clock; all state on rising edge.
- REQ-004: RST_N  in  1  asynchronous, active-low reset.
- REQ-005: START  in  1  one-cycle request to fetch a vertex range.
- REQ-006: BASE_ADDR  in  AW  first vertex index.
- REQ-007: COUNT  in  AW+1  number of vertices to fetch (0..DEPTH).
- REQ-008: BUSY  out  1  high from accepted START until the DONE cycle inclusive.
- REQ-009: DONE  out  1  one-cycle pulse when the range is fully delivered.
- REQ-010: VB_ADDR  out  AW  read address to a vertex buffer read port (1-cycle registered read).
- REQ-011: VB_Q  in  DW  read data from that port, valid the cycle after VB_ADDR is presented.
- REQ-012: V_VALID  out  1  output vertex valid.
- REQ-013: V_READY  in  1  downstream accept; transfer when V_VALID and V_READY are both high at a rising edge.
- REQ-014: V_X, V_Y, V_Z  out  16 each  VB_Q[15:0], [31:16], [47:32].
- REQ-015: V_COLOR  out  8  VB_Q[55:48], RGB332.
- REQ-016: V_UV  out  4  VB_Q[63:60]; VB_Q[59:56] is ignored.
- REQ-017: V_LAST  out  1  high with the final vertex of the range.

Function
- REQ-018: FSM states are IDLE, FETCH, DRAIN and FIN.
- REQ-019: IDLE, START=1, COUNT!=0: latch address <= BASE_ADDR and remaining <= COUNT, then go to FETCH.
- REQ-020: IDLE, START=1, COUNT=0: go to FIN; no read is issued and no vertex is output.
- REQ-021: START is ignored in every state except IDLE.
- REQ-022: FETCH issues one read per cycle while (FIFO occupancy + reads in flight) < 4.
- REQ-023: Each read drives VB_ADDR = address; afterwards address <= (address+1) mod DEPTH and remaining decrements.
- REQ-024: When the read with remaining=1 is issued, the FSM goes to DRAIN.
- REQ-025: The cycle after each issued read, VB_Q is unpacked and written, with its last flag, into a 4-entry output FIFO.
- REQ-026: The 4-entry FIFO never overflows, by the credit rule in REQ-022.
- REQ-027: V_VALID = FIFO not empty; the output fields show the FIFO head.
- REQ-028: Head fields stay stable while V_VALID=1 and V_READY=0.
- REQ-029: Latency: with START accepted at edge k, VB_ADDR=BASE_ADDR after edge k, and the first V_VALID goes high after edge k+2.
- REQ-030: Throughput: with V_READY held at 1, one vertex transfers per cycle with no bubbles after the first.
- REQ-031: In the same cycle, a FIFO push and pop are both honoured and occupancy stays the same.
- REQ-032: Address wraps DEPTH-1 -> 0 within one range.
- REQ-033: COUNT=DEPTH fetches every entry exactly once.
- REQ-034: DRAIN goes to FIN after the edge where the FIFO becomes empty and no read is in flight.
- REQ-035: FIN lasts exactly one cycle, with DONE=1 and BUSY=1, then goes to IDLE.
- REQ-036: VB_ADDR holds its last value when no read is issued.

Reset
- REQ-037: RST_N low, at any time including mid-range, immediately forces: state IDLE; FIFO empty; in-flight count 0.
- REQ-038: Under the same reset, these outputs are 0: BUSY, DONE, V_VALID, V_LAST, VB_ADDR, and all V_* fields.
- REQ-039: After reset release, no vertex from an aborted range is output.

Verification
- REQ-040: Buffer preloaded with word i = {4'hA, 4'h0, 8'(i), 16'(3i), 16'(2i), 16'(i)}; START with BASE=5, COUNT=3, V_READY=1 -> three transfers with X=5,6,7 on consecutive cycles, first V_VALID at edge k+2, V_LAST only on X=7, DONE one cycle after the last transfer.
- REQ-041: BASE=1022, COUNT=4, DEPTH=1024 -> VB_ADDR sequence 1022, 1023, 0, 1; X sequence equals that sequence.
- REQ-042: COUNT=0 -> BUSY=1 and DONE=1 in the single cycle after START; V_VALID never asserts.
- REQ-043: Random V_READY (50%), COUNT=20 -> 20 transfers in order with no loss or duplication, fields stable while stalled, at most 4 reads outstanding plus buffered.
- REQ-044: RST_N pulsed low after 2 of 10 vertices -> all outputs 0 asynchronously; a following START with BASE=0, COUNT=1 delivers only vertex 0.
- REQ-045: START pulsed while BUSY -> ignored; the current range completes unchanged and only one DONE pulse occurs.

Source files
------------

// File: rtl/vertex_fetch.sv
// Vertex range fetcher: reads a vertex buffer through a 1-cycle registered port and
// unpacks each word into a 4-entry output FIFO with valid/ready handshake.
module vertex_fetch #(
    parameter int DEPTH = 1024,
    parameter int DW    = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic [AW:0]   COUNT,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] VB_ADDR,
    input  logic [DW-1:0] VB_Q,
    output logic          V_VALID,
    input  logic          V_READY,
    output logic [15:0]   V_X,
    output logic [15:0]   V_Y,
    output logic [15:0]   V_Z,
    output logic [7:0]    V_COLOR,
    output logic [3:0]    V_UV,
    output logic          V_LAST,
    output logic [1:0]    DBG_STATE
);

    // Handshake: a vertex moves downstream on a rising edge where V_VALID and V_READY
    // are both high; V_VALID never depends on V_READY and the head holds while stalled.

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FIN} state_t;

    localparam logic [AW:0] REM_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state, state_nx;
    logic [AW-1:0] addr;
    logic [AW-1:0] vb_addr_q;
    logic [AW:0]   remaining;
    logic          rd_pend;
    logic          rd_last;
    logic [60:0]   fifo_mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    fifo_cnt;
    logic          issue;
    logic          credit_ok;
    logic          push;
    logic          pop;
    logic [60:0]   head;
    logic          vb_q_unused;

    assign vb_q_unused = ^VB_Q[59:56];

    assign credit_ok = ({1'b0, fifo_cnt} + {3'b000, rd_pend}) < 4'd4;
    assign push      = rd_pend;
    assign pop       = V_VALID && V_READY;
    assign V_VALID   = (fifo_cnt != 3'd0);
    assign VB_ADDR   = issue ? addr : vb_addr_q;
    assign DBG_STATE = state;

    // Fields are forced to zero whenever nothing is buffered, including under reset.
    assign head = V_VALID ? fifo_mem[rd_ptr] : '0;
    assign {V_X, V_Y, V_Z, V_COLOR, V_UV, V_LAST} = head;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (START) state_nx = (COUNT == '0) ? S_FIN : S_FETCH;
            S_FETCH: if (issue && (remaining == REM_ONE)) state_nx = S_DRAIN;
            // Leave on the edge that empties the FIFO, so DONE follows the last transfer.
            S_DRAIN: if (!rd_pend && ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop)))
                         state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY  = (state != S_IDLE);
        DONE  = (state == S_FIN);
        issue = (state == S_FETCH) && credit_ok;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr      <= '0;
            vb_addr_q <= '0;
            remaining <= '0;
            rd_pend   <= 1'b0;
            rd_last   <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            fifo_cnt  <= 3'd0;
        end else begin
            if ((state == S_IDLE) && START && (COUNT != '0)) begin
                addr      <= BASE_ADDR;
                remaining <= COUNT;
            end else if (issue) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - REM_ONE;
                vb_addr_q <= addr;
            end
            rd_pend <= issue;
            rd_last <= issue && (remaining == REM_ONE);
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage only; occupancy and pointers decide what is visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {VB_Q[15:0], VB_Q[31:16], VB_Q[47:32], VB_Q[55:48],
                                 VB_Q[63:60], rd_last};
        end
    end

endmodule

// File: tb/tb_vertex_fetch.sv
// Bench for vertex_fetch: table of vertex ranges plus random ranges, checked against
// a model that derives every vertex straight from the buffer fill rule.
module tb_vertex_fetch;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [AW-1:0] BASE_ADDR;
    logic [AW:0]   COUNT;
    logic          BUSY;
    logic          DONE;
    logic [AW-1:0] VB_ADDR;
    logic [63:0]   VB_Q;
    logic          V_VALID;
    logic          V_READY;
    logic [15:0]   V_X, V_Y, V_Z;
    logic [7:0]    V_COLOR;
    logic [3:0]    V_UV;
    logic          V_LAST;
    logic [1:0]    dbg_state;

    logic [63:0] vb_mem [DEPTH];
    logic [60:0] exp_q[$];
    int checks;
    int errors;

    typedef struct {
        int base;
        int cnt;
        int pct;
        bit poke;
        int exp_xfers;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs[8];

    vertex_fetch #(.DEPTH(DEPTH), .DW(64)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
        .BUSY(BUSY), .DONE(DONE), .VB_ADDR(VB_ADDR), .VB_Q(VB_Q), .V_VALID(V_VALID),
        .V_READY(V_READY), .V_X(V_X), .V_Y(V_Y), .V_Z(V_Z), .V_COLOR(V_COLOR),
        .V_UV(V_UV), .V_LAST(V_LAST), .DBG_STATE(dbg_state)
    );

    // Clock and vertex buffer with a registered read port
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        for (int i = 0; i < DEPTH; i++)
            vb_mem[i] = {4'hA, 4'h0, 8'(i), 16'(3 * i), 16'(2 * i), 16'(i)};
    end

    always @(posedge CLK) VB_Q <= vb_mem[VB_ADDR];

    function automatic logic [60:0] model_vertex(input int a, input bit last);
        logic [15:0] x, y, z;
        x = 16'(a);
        y = 16'(2 * a);
        z = 16'(3 * a);
        return {x, y, z, 8'(a), 4'hA, last};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_valid"}, V_VALID, 0);
        chk({tag, "_last"}, V_LAST, 0);
        chk({tag, "_vb_addr"}, VB_ADDR, 0);
        chk({tag, "_fields"}, {V_X, V_Y, V_Z, V_COLOR, V_UV}, 0);
    endtask

    // Driver + scoreboard for one range; called at posedge+1 with the DUT idle.
    task automatic run_range(input int base, input int cnt, input int pct, input bit poke,
                             output int n_xfer, output int first_x, output int last_x);
        int issued, xfers, last_xfer, budget, prev_addr;
        bit stalled, rdy, finished;
        logic [60:0] head, prev_head, exp;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) exp_q.push_back(model_vertex((base + i) % DEPTH, i == cnt - 1));
        first_x = -1;
        last_x = -1;
        xfers = 0;
        BASE_ADDR = AW'(base);
        COUNT = (AW + 1)'(cnt);
        V_READY = 1'b0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("busy_after_start", BUSY, 1);
        if (cnt == 0) begin
            chk("done_count0", DONE, 1);
            chk("valid_count0", V_VALID, 0);
            @(posedge CLK); #1;
            chk("busy_clear_count0", BUSY, 0);
            chk("done_clear_count0", DONE, 0);
            chk("valid_count0_after", V_VALID, 0);
            n_xfer = 0;
            return;
        end
        chk("first_addr", VB_ADDR, base);
        issued = 1;
        prev_addr = base;
        budget = cnt * 8 + 50;
        finished = 0;
        stalled = 0;
        last_xfer = -1;
        prev_head = '0;
        for (int n = 0; n < budget && !finished; n++) begin
            if (n > 0 && int'(VB_ADDR) != prev_addr) begin
                issued++;
                chk("vb_addr_seq", VB_ADDR, (base + issued - 1) % DEPTH);
                prev_addr = int'(VB_ADDR);
            end
            chk("outstanding_le4", (issued - xfers) <= 4, 1);
            head = {V_X, V_Y, V_Z, V_COLOR, V_UV, V_LAST};
            if (stalled) chk("stall_hold", head, prev_head);
            if (n == 1) chk("valid_at_k1", V_VALID, 0);
            if (n == 2) chk("valid_at_k2", V_VALID, 1);
            if (DONE) begin
                chk("done_after_last_xfer", n, last_xfer + 1);
                chk("busy_with_done", BUSY, 1);
                chk("all_delivered_at_done", exp_q.size(), 0);
                finished = 1;
            end
            rdy = ($urandom_range(0, 99) < pct);
            V_READY = rdy;
            START = poke && (n == 3 || DONE);
            if (poke) BASE_ADDR = '0;
            if (V_VALID && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_vertex actual x=%0d expected none", V_X);
                end else begin
                    exp = exp_q.pop_front();
                    chk("vertex", head, exp);
                end
                if (pct == 100 && xfers > 0) chk("no_bubble", n, last_xfer + 1);
                if (xfers == 0) first_x = int'(V_X);
                last_x = int'(V_X);
                xfers++;
                last_xfer = n;
            end
            stalled = V_VALID && !rdy;
            prev_head = head;
            @(posedge CLK); #1;
        end
        START = 1'b0;
        V_READY = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL range_timeout actual=no_done expected=done base=%0d cnt=%0d", base, cnt);
        end
        chk("busy_after_done", BUSY, 0);
        chk("done_one_cycle", DONE, 0);
        chk("valid_after_done", V_VALID, 0);
        @(posedge CLK); #1;
        chk("single_done", DONE, 0);
        chk("idle_after_done", BUSY, 0);
        n_xfer = xfers;
    endtask

    initial begin
        int nx, fx, lx, base, cnt, pct, xf;
        vecs[0] = '{5,    3,    100, 0, 3,    5,    7};
        vecs[1] = '{1022, 4,    100, 0, 4,    1022, 1};
        vecs[2] = '{0,    0,    100, 0, 0,    0,    0};
        vecs[3] = '{37,   20,   50,  0, 20,   37,   56};
        vecs[4] = '{200,  1,    100, 0, 1,    200,  200};
        vecs[5] = '{700,  10,   50,  1, 10,   700,  709};
        vecs[6] = '{500,  1024, 100, 0, 1024, 500,  499};
        vecs[7] = '{900,  7,    30,  0, 7,    900,  906};
        checks = 0;
        errors = 0;
        RST_N = 1'b0;
        START = 1'b0;
        BASE_ADDR = '0;
        COUNT = '0;
        V_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_zero_outputs("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;

        foreach (vecs[i]) begin
            run_range(vecs[i].base, vecs[i].cnt, vecs[i].pct, vecs[i].poke, nx, fx, lx);
            chk("table_xfers", nx, vecs[i].exp_xfers);
            if (vecs[i].exp_xfers > 0) begin
                chk("table_first_x", fx, vecs[i].exp_first);
                chk("table_last_x", lx, vecs[i].exp_last);
            end
        end

        for (int r = 0; r < 6; r++) begin
            base = $urandom_range(0, DEPTH - 1);
            cnt = $urandom_range(1, 40);
            pct = $urandom_range(20, 100);
            run_range(base, cnt, pct, 0, nx, fx, lx);
            chk("rand_xfers", nx, cnt);
            chk("rand_first_x", fx, base);
        end

        // Reset in the middle of a range, after two vertices have left
        BASE_ADDR = 10'd100;
        COUNT = 11'd10;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        V_READY = 1'b1;
        xf = 0;
        for (int n = 0; n < 40 && xf < 2; n++) begin
            if (V_VALID) xf++;
            @(posedge CLK); #1;
        end
        chk("midrange_two_xfers", xf, 2);
        #2;
        RST_N = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        @(posedge CLK); #1;
        chk_zero_outputs("held_reset");
        RST_N = 1'b1;
        V_READY = 1'b0;
        @(posedge CLK); #1;
        chk("post_reset_idle", BUSY, 0);
        run_range(0, 1, 100, 0, nx, fx, lx);
        chk("post_reset_xfers", nx, 1);
        chk("post_reset_x", fx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
